exe_mem_flow_ctrl: RTL and testbench
====================================

# exe_mem_flow_ctrl

Pipeline flow controller for the EXE→MEM boundary. Sequences the iterative divider in EXE, converts divider occupancy and data-memory wait into freeze/bubble commands for the EXE/MEM pipeline register and for the upstream stages, and gives exceptions priority over both. `em_stall` drives the register's `stall0`, and `em_clr` drives its `clr`. The register's own `irq` input is wired from the same exception line.

## Interface
- `DIV_CYCLES`, default 32: divider iteration count; legal range 2..63.
- `CNT_W`, default 6: width of the iteration counter.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `div_req`  in  1: instruction in EXE is DIV/DIVU; held until the instruction leaves EXE.
- `div_by_zero`  in  1: divisor operand is zero; qualified by `div_req`.
- `mem_req`  in  1: instruction in MEM is accessing data memory.
- `mem_ack`  in  1: data memory completes the access this cycle.
- `irq`  in  1: exception or interrupt taken this cycle.
- `div_start`  out  1: one-cycle pulse that loads the divider operands.
- `div_abort`  out  1: one-cycle pulse that cancels a running divide.
- `div_done`  out  1: divider result is valid and is captured into EXE/MEM this cycle.
- `em_stall`  out  1: freeze EXE/MEM; connects to `stall0`.
- `em_clr`  out  1: load a bubble into EXE/MEM; connects to `clr`.
- `up_stall`  out  1: freeze PC, IF/ID and ID/EXE.
- `stall_cycles`  out  32: saturating count of cycles with `up_stall`=1.

## Operation
- `mem_wait = mem_req & ~mem_ack & ~irq`. `em_stall = mem_wait`.
- Divider FSM has three states: IDLE, RUN, DONE. There is one CNT_W-bit down-counter `cnt`.
- IDLE
  - `div_start` = `div_req & ~irq & ~mem_wait`.
  - On `div_start`: `cnt` ← DIV_CYCLES−1, next state RUN.
- RUN
  - `irq`: `div_abort`=1, next state IDLE.
  - Otherwise, if `cnt`==0: next state DONE.
  - Otherwise: `cnt` ← `cnt`−1.
- DONE
  - `div_done = ~mem_wait & ~irq`.
  - If `div_done`, `irq` or `~div_req`: next state IDLE. Otherwise remain in DONE, holding the result until MEM drains.
- `div_busy` = (state==IDLE & `div_req`) | state==RUN.
- `up_stall` = `(mem_wait | div_busy) & ~irq`.
- `em_clr` = `irq | (div_busy & ~mem_wait)`.
  - While the divider is busy and MEM is free, bubbles enter MEM so the instruction in MEM is not replayed.
  - `mem_wait` takes precedence over the bubble: freeze, do not clear.
- `irq` overrides everything in the same cycle:
  - `em_clr`=1, `em_stall`=0, `up_stall`=0.
  - No `div_start`; the FSM returns to IDLE.
- `stall_cycles`: +1 on each cycle with `up_stall`=1; holds at 0xFFFF_FFFF.

## Timing
- Reset values:
  - FSM = IDLE, `cnt`=0, `stall_cycles`=0.
  - All 1-bit outputs are 0 with inputs low.
  - All outputs except `stall_cycles` are combinational from state and inputs; `stall_cycles` is registered.
- Divide latency:
  - `div_req` rises at cycle 0 (IDLE, no wait): `div_start` in cycle 0.
  - RUN in cycles 1..DIV_CYCLES.
  - DONE in cycle DIV_CYCLES+1, with `div_done`=1 and `up_stall`=0.
  - `up_stall`=1 and `em_clr`=1 in cycles 0..DIV_CYCLES, i.e. DIV_CYCLES+1 stall cycles.
- `div_req` in IDLE while `mem_wait`=1:
  - `div_start` is deferred. `up_stall`=1, `em_stall`=1, `em_clr`=0.
  - Start occurs in the first cycle with `mem_wait`=0.
- `mem_wait` while in DONE: stay in DONE and hold `div_done`=0. `div_done` goes to 1 in the cycle `mem_ack` arrives.
- Reset asserted mid-RUN: FSM returns to IDLE immediately. No `div_abort` pulse is generated.

## Configuration
- `DIV_ZERO_SKIP_EN`
  - Defined: in IDLE, `div_start & div_by_zero` skips RUN and goes straight to DONE. Latency is 1 stall cycle, and the result is the divider's undefined-by-ISA value.
  - Undefined: `div_by_zero` is ignored and a zero-divisor divide takes the full DIV_CYCLES.

## Test plan
- DIV_CYCLES=32, one isolated DIV, `mem_req`=0 → `div_start` at cycle 0; `up_stall`=1 and `em_clr`=1 for 33 cycles; `div_done`=1 at cycle 33; `stall_cycles`=33.
- DIV whose `div_req` rises while MEM waits 3 cycles for `mem_ack` → `em_stall`=1 and `em_clr`=0 for 3 cycles; `div_start` on cycle 3; `div_done` at cycle 36.
- `irq` at RUN cycle 10 → `div_abort`=1, `em_clr`=1, `up_stall`=0 in that cycle; FSM is IDLE on the next cycle; no `div_done`.
- DONE coincident with a 2-cycle `mem_wait` → FSM holds DONE for 2 cycles with `div_done`=0; `div_done`=1 on the ack cycle; IDLE next.
- `DIV_ZERO_SKIP_EN` defined, `div_by_zero`=1 → DONE in cycle 1 with `div_done`=1; with the macro undefined → `div_done` at cycle 33.
- `stall_cycles` forced to 0xFFFF_FFFE, then 3 stall cycles → the counter reads 0xFFFF_FFFF and holds.

Source files
------------

// File: rtl/exe_mem_flow_ctrl.sv
// EXE->MEM flow controller: sequences the iterative divider and turns divider occupancy,
// data-memory wait and exceptions into EXE/MEM freeze/bubble and upstream stall. Option: DIV_ZERO_SKIP_EN.
module exe_mem_flow_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        div_req,
   input  logic        div_by_zero,
   input  logic        mem_req,
   input  logic        mem_ack,
   input  logic        irq,
   output logic        div_start,
   output logic        div_abort,
   output logic        div_done,
   output logic        em_stall,
   output logic        em_clr,
   output logic        up_stall,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      stall_cycles_reg;
   logic [31:0]      stall_cycles_next;
   logic             mem_wait;
   logic             div_busy;

   // An exception cancels the memory wait so the pipeline can flush instead of freezing.
   assign mem_wait = mem_req & ~mem_ack & ~irq;
   assign div_busy = ((state_reg == IDLE) & div_req) | (state_reg == RUN);

   assign em_stall = mem_wait;
   assign up_stall = (mem_wait | div_busy) & ~irq;
   // Bubbles keep the instruction already in MEM from being replayed while the divider works.
   assign em_clr   = irq | (div_busy & ~mem_wait);

`ifndef DIV_ZERO_SKIP_EN
   logic unused_div_by_zero;
   assign unused_div_by_zero = div_by_zero;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      div_start  = 1'b0;
      div_abort  = 1'b0;
      div_done   = 1'b0;
      case (state_reg)
         IDLE: begin
            div_start = div_req & ~irq & ~mem_wait;
            if (div_start) begin
`ifdef DIV_ZERO_SKIP_EN
               if (div_by_zero) begin
                  state_next = DONE;
               end else begin
                  cnt_next   = CNT_W'(DIV_CYCLES - 1);
                  state_next = RUN;
               end
`else
               cnt_next   = CNT_W'(DIV_CYCLES - 1);
               state_next = RUN;
`endif
            end
         end
         RUN: begin
            if (irq) begin
               div_abort  = 1'b1;
               state_next = IDLE;
            end else if (cnt_reg == '0) begin
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         DONE: begin
            // Result is held here until MEM drains, then captured in the same cycle.
            div_done = ~mem_wait & ~irq;
            if (div_done | irq | ~div_req) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign stall_cycles_next = (up_stall && (stall_cycles_reg != 32'hFFFF_FFFF))
                              ? stall_cycles_reg + 32'd1 : stall_cycles_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_reg <= '0;
      end else begin
         stall_cycles_reg <= stall_cycles_next;
      end
   end

   assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_exe_mem_flow_ctrl.sv
// Directed self-checking bench for exe_mem_flow_ctrl with DIV_CYCLES=32.
module tb_exe_mem_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        div_req, div_by_zero, mem_req, mem_ack, irq;
   logic        div_start, div_abort, div_done, em_stall, em_clr, up_stall;
   logic [31:0] stall_cycles;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [31:0] exp_stall;

   exe_mem_flow_ctrl #(
      .DIV_CYCLES(32),
      .CNT_W     (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .div_req     (div_req),
      .div_by_zero (div_by_zero),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .irq         (irq),
      .div_start   (div_start),
      .div_abort   (div_abort),
      .div_done    (div_done),
      .em_stall    (em_stall),
      .em_clr      (em_clr),
      .up_stall    (up_stall),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic st, input logic ab, input logic dn,
                             input logic es, input logic ec, input logic us);
      check({tag, ".div_start"}, 32'(div_start), 32'(st));
      check({tag, ".div_abort"}, 32'(div_abort), 32'(ab));
      check({tag, ".div_done"},  32'(div_done),  32'(dn));
      check({tag, ".em_stall"},  32'(em_stall),  32'(es));
      check({tag, ".em_clr"},    32'(em_clr),    32'(ec));
      check({tag, ".up_stall"},  32'(up_stall),  32'(us));
   endtask

   // Advance to just after the next rising edge; inputs are driven here, outputs checked 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; div_req = 1'b0; div_by_zero = 1'b0;
      mem_req = 1'b0; mem_ack = 1'b0; irq = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 0, 0, 0, 0, 0, 0);
      check("reset.stall_cycles", stall_cycles, 32'd0);
      rst_n = 1'b1;
      $display("[TB] reset checked");

      // Isolated divide: start at cycle 0, RUN 1..32, DONE at 33.
      tick(); div_req = 1'b1; #1;
      for (int c = 0; c <= 32; c++) begin
         if (c > 0) begin tick(); #1; end
         check_outs("div1.busy", (c == 0), 0, 0, 0, 1, 1);
      end
      tick(); #1;
      check_outs("div1.done", 0, 0, 1, 0, 0, 0);
      check("div1.stall_cycles", stall_cycles, 32'd33);
      tick(); div_req = 1'b0; #1;
      check_outs("div1.idle", 0, 0, 0, 0, 0, 0);
      check("div1.stall_hold", stall_cycles, 32'd33);
      $display("[TB] isolated divide checked");

      // Divide requested while MEM waits 3 cycles.
      tick(); mem_req = 1'b1; div_req = 1'b1; #1;
      for (int c = 0; c <= 2; c++) begin
         if (c > 0) begin tick(); #1; end
         check_outs("memw.defer", 0, 0, 0, 1, 0, 1);
      end
      tick(); mem_ack = 1'b1; #1;
      check_outs("memw.start", 1, 0, 0, 0, 1, 1);
      for (int c = 4; c <= 35; c++) begin
         tick();
         if (c == 4) begin mem_req = 1'b0; mem_ack = 1'b0; end
         #1;
         check("memw.run.done", 32'(div_done), 32'd0);
         check("memw.run.up_stall", 32'(up_stall), 32'd1);
      end
      tick(); #1;
      check_outs("memw.done", 0, 0, 1, 0, 0, 0);
      check("memw.stall_cycles", stall_cycles, 32'd69);
      tick(); div_req = 1'b0; #1;
      check("memw.idle.done", 32'(div_done), 32'd0);
      $display("[TB] divide behind memory wait checked");

      // Exception during RUN cycle 10, with a memory request that must not freeze.
      tick(); div_req = 1'b1; #1;
      check("irq.start", 32'(div_start), 32'd1);
      for (int c = 1; c <= 9; c++) begin
         tick(); #1;
         check("irq.run.abort", 32'(div_abort), 32'd0);
      end
      tick(); irq = 1'b1; mem_req = 1'b1; #1;
      check_outs("irq.hit", 0, 1, 0, 0, 1, 0);
      tick(); irq = 1'b0; mem_req = 1'b0; div_req = 1'b0; #1;
      check_outs("irq.after", 0, 0, 0, 0, 0, 0);
      check("irq.stall_cycles", stall_cycles, 32'd79);
      $display("[TB] exception abort checked");

      // DONE coincident with a 2-cycle memory wait.
      tick(); div_req = 1'b1; #1;
      for (int c = 1; c <= 32; c++) begin tick(); #1; end
      for (int c = 33; c <= 34; c++) begin
         tick(); mem_req = 1'b1; #1;
         check_outs("donew.hold", 0, 0, 0, 1, 0, 1);
      end
      tick(); mem_ack = 1'b1; #1;
      check_outs("donew.ack", 0, 0, 1, 0, 0, 0);
      tick(); mem_req = 1'b0; mem_ack = 1'b0; div_req = 1'b0; #1;
      check_outs("donew.idle", 0, 0, 0, 0, 0, 0);
      check("donew.stall_cycles", stall_cycles, 32'd114);
      $display("[TB] done under memory wait checked");

      // Zero divisor.
      tick(); div_req = 1'b1; div_by_zero = 1'b1; #1;
      check("dz.start", 32'(div_start), 32'd1);
      tick(); #1;
`ifdef DIV_ZERO_SKIP_EN
      check("dz.done_c1", 32'(div_done), 32'd1);
      check("dz.up_stall_c1", 32'(up_stall), 32'd0);
      exp_stall = 32'd115;
`else
      check("dz.done_c1", 32'(div_done), 32'd0);
      check("dz.up_stall_c1", 32'(up_stall), 32'd1);
      for (int c = 2; c <= 32; c++) begin tick(); #1; end
      tick(); #1;
      check("dz.done_c33", 32'(div_done), 32'd1);
      exp_stall = 32'd147;
`endif
      tick(); div_req = 1'b0; div_by_zero = 1'b0; #1;
      check("dz.idle.done", 32'(div_done), 32'd0);
      check("dz.stall_cycles", stall_cycles, exp_stall);
      $display("[TB] zero-divisor divide checked");

      // Asynchronous reset in the middle of RUN.
      tick(); div_req = 1'b1; #1;
      for (int c = 1; c <= 5; c++) begin tick(); #1; end
      rst_n = 1'b0; div_req = 1'b0; #1;
      check_outs("rstrun", 0, 0, 0, 0, 0, 0);
      check("rstrun.stall_cycles", stall_cycles, 32'd0);
      tick(); rst_n = 1'b1; #1;
      check_outs("rstrun.after", 0, 0, 0, 0, 0, 0);
      $display("[TB] reset during RUN checked");

      // Saturation of the stall counter.
      tick(); force dut.stall_cycles_next = 32'hFFFF_FFFE;
      tick(); release dut.stall_cycles_next; #1;
      check("sat.preload", stall_cycles, 32'hFFFF_FFFE);
      div_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(); #1;
         check("sat.hold", stall_cycles, 32'hFFFF_FFFF);
      end
      div_req = 1'b0;
      $display("[TB] stall counter saturation checked");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
